// File: rtl/int_to_fp.sv
// int_to_fp: multi-cycle int32/uint32 to IEEE-754 single-precision converter.
// FSM IDLE -> ABS -> NORM -> ROUND -> DONE with valid/ready handshakes on both sides.
// SIGNED=1 treats in_data as two's complement, SIGNED=0 as unsigned.
// Define INT_TO_FP_FASTNORM_EN for a single-cycle priority-encoder NORM stage;
// otherwise NORM shifts one bit per cycle. Results are bit-identical in both builds.
module int_to_fp #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StAbs, StNorm, StRound, StDone} state_e;

  // Biased exponent of a magnitude whose top set bit is bit 31.
  localparam logic [7:0] ExpTop = 8'd158;

  state_e      state_q;
  logic [31:0] operand_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic        zero_q;
  logic [31:0] out_data_q;

  // Sign and magnitude of the captured operand; 0x80000000 maps onto itself.
  logic        neg;
  logic [31:0] abs_mag;
  assign neg     = SIGNED && operand_q[31];
  assign abs_mag = neg ? (~operand_q + 32'd1) : operand_q;

  // Round to nearest even on the normalised magnitude; bit 31 is the hidden one.
  logic        round_up;
  logic [23:0] mant_inc;
  logic [7:0]  exp_rnd;
  assign round_up = mag_q[7] && ((|mag_q[6:0]) || mag_q[8]);
  assign mant_inc = {1'b0, mag_q[30:8]} + {23'd0, round_up};
  assign exp_rnd  = exp_q + {7'd0, mant_inc[23]};

  logic unused_hidden_bit;
  assign unused_hidden_bit = mag_q[31];

`ifdef INT_TO_FP_FASTNORM_EN
  // Leading-zero count of the magnitude; the highest set bit wins.
  logic [4:0] lz;
  always_comb begin
    lz = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag_q[i]) lz = 5'(31 - i);
    end
  end
`endif

  // Control FSM with all datapath registers and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      operand_q  <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_q      <= '0;
      zero_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            operand_q <= in_data;
            state_q   <= StAbs;
          end
        end
        StAbs: begin
          sign_q <= neg;
          mag_q  <= abs_mag;
          exp_q  <= ExpTop;
          if (abs_mag == 32'd0) begin
            // Zero spends a second cycle here so its latency matches the lz == 0 path.
            if (zero_q) begin
              zero_q     <= 1'b0;
              out_data_q <= '0;
              state_q    <= StDone;
            end else begin
              zero_q <= 1'b1;
            end
          end else if (abs_mag[31]) begin
            state_q <= StRound;
          end else begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
`ifdef INT_TO_FP_FASTNORM_EN
          mag_q   <= mag_q << lz;
          exp_q   <= exp_q - {3'd0, lz};
          state_q <= StRound;
`else
          mag_q <= mag_q << 1;
          exp_q <= exp_q - 8'd1;
          if (mag_q[30]) state_q <= StRound;
`endif
        end
        StRound: begin
          // A mantissa carry-out leaves mant_inc[22:0] at zero and bumps the exponent.
          out_data_q <= {sign_q, exp_rnd, mant_inc[22:0]};
          state_q    <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: directed and randomised checks of int_to_fp (SIGNED=1 and SIGNED=0
// instances) against an arithmetic reference model of integer-to-float rounding.
module tb_int_to_fp;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_data  [2];
  logic        busy      [2];

  int n_checks;
  int n_pass;

  // Instance 0 is signed, instance 1 unsigned.
  int_to_fp #(.SIGNED(1'b1)) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_data (out_data[0]),
    .busy     (busy[0])
  );

  int_to_fp #(.SIGNED(1'b0)) dut_u (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_data (out_data[1]),
    .busy     (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  // Exact magnitude of the operand as an integer.
  function automatic longint ref_mag(input logic [31:0] a, input int u);
    longint v;
    v = (u == 1) ? longint'(a) : longint'($signed(a));
    return (v < 0) ? -v : v;
  endfunction

  // Position of the most significant set bit (mag must be nonzero).
  function automatic int ref_msb(input longint mag);
    int p;
    p = 31;
    while (((mag >> p) & 1) == 0) p--;
    return p;
  endfunction

  // Integer to single precision, round to nearest even, from plain arithmetic.
  function automatic logic [31:0] ref_fp(input logic [31:0] a, input int u);
    longint mag, q, rem, half;
    int p, s;
    logic sgn;
    logic [7:0] e;
    logic [22:0] m;
    mag = ref_mag(a, u);
    if (mag == 0) return 32'h0;
    sgn = (u == 0) && a[31];
    p = ref_msb(mag);
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      s = p - 23;
      q = mag >> s;
      rem = mag - (q << s);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    e = 8'(127 + p);
    m = 23'(q);
    return {sgn, e, m};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input int u);
    longint mag;
    int lz;
    mag = ref_mag(a, u);
    if (mag == 0) return 2;
    lz = 31 - ref_msb(mag);
`ifdef INT_TO_FP_FASTNORM_EN
    return (lz > 0) ? 3 : 2;
`else
    return 2 + lz;
`endif
  endfunction

  // One full transaction: accept, wait for result, hold off 'hold' cycles, hand off.
  task automatic convert(input int u, input logic [31:0] a, input logic [31:0] want,
                         input int hold, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = a;
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      if (out_valid[u]) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(ref_lat(a, u)));
    check({tag, " result"}, out_data[u], want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " held data"}, out_data[u], want);
      check({tag, " held in_ready"}, 32'(in_ready[u]), 32'd0);
    end
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    check({tag, " in_ready after handoff"}, 32'(in_ready[u]), 32'd1);
    check({tag, " data kept in idle"}, out_data[u], want);
  endtask

  initial begin
    logic [31:0] a;
    int u;
    n_checks = 0;
    n_pass   = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid[0]), 32'd0);
    check("reset in_ready", 32'(in_ready[0]), 32'd1);
    check("reset busy", 32'(busy[1]), 32'd0);
    check("reset out_data", out_data[1], 32'h0);
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    // Operand presented without in_valid must be ignored.
    in_data[0] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("idle ignores data", 32'(busy[0]), 32'd0);

    convert(0, 32'h0000_0001, 32'h3F80_0000, 0, "one");
    convert(0, 32'hFFFF_FFFF, 32'hBF80_0000, 0, "minus one");
    convert(0, 32'h0000_0000, 32'h0000_0000, 0, "zero");
    convert(0, 32'h8000_0000, 32'hCF00_0000, 0, "int min signed");
    convert(1, 32'h8000_0000, 32'h4F00_0000, 0, "2^31 unsigned");
    convert(0, 32'h0100_0001, 32'h4B80_0000, 0, "tie to even");
    convert(0, 32'h0100_0003, 32'h4B80_0002, 0, "tie rounds up");
    convert(0, 32'h7FFF_FFFF, 32'h4F00_0000, 0, "carry out");
    convert(0, 32'h0000_0064, 32'h42C8_0000, 5, "backpressure");

    // Reset in the middle of NORM drops the operand.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid-norm busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-norm rst out_valid", 32'(out_valid[0]), 32'd0);
    check("mid-norm rst out_data", out_data[0], 32'h0);
    check("mid-norm rst in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    convert(0, 32'h0000_0003, 32'h4040_0000, 0, "after reset");

    // Random operands over both signedness variants, with varied magnitude widths.
    for (int n = 0; n < 300; n++) begin
      u = n % 2;
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = -a;
      convert(u, a, ref_fp(a, u), $urandom_range(0, 2), (u == 1) ? "rand unsigned" : "rand signed");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
